dummy_interface: RTL and testbench
==================================

DUMMY_INTERFACE -- requirements
Module: dummy_interface

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, is the read-response timeout in clocks; it is used only when DUMMY_IF_TIMEOUT_EN is defined.
REQ-002 algorithm_clock  in  1  sole clock; all logic is rising-edge on this clock.
REQ-003 algorithm_reset  in  1  asynchronous, active-low reset.
REQ-004 algorithm_start  in  1  single-cycle request to start one lookup.
REQ-005 algorithm_enable  in  1  reserved; it SHALL have no functional effect.
REQ-006 base_address  in  32  word address to read.
REQ-007 datab  in  32  offset added to the returned data.
REQ-008 mem_read_enable  out  1  read request (Avalon-MM style read).
REQ-009 mem_addr  out  32  read address.
REQ-010 wait_request  in  1  memory stall; the request is not accepted while this is high.
REQ-011 mem_read_ready  in  1  read-data-valid strobe.
REQ-012 mem_read_data  in  32  read data; narrower sources are zero-extended.
REQ-013 shortest_distance  out  32  result.
REQ-014 ready  out  1  completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, a start input sampled high SHALL latch base_address and datab, set mem_addr to the latched base_address, and go to REQ.
- mem_read_enable SHALL be high from the next cycle.
REQ-017 In REQ, mem_read_enable SHALL be held high with mem_addr stable while wait_request is high.
- On a cycle with wait_request low, the request is accepted.
- mem_read_enable SHALL drop on the next edge, and the FSM SHALL go to WAIT.
REQ-018 Only one read SHALL be issued per start.
- mem_read_ready SHALL be ignored in IDLE and REQ.
REQ-019 In WAIT, when mem_read_ready is high, shortest_distance SHALL be set to mem_read_data + latched datab, truncated to 32 bits (wrap-around), and the FSM SHALL go to DONE.
REQ-020 In DONE, ready SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 shortest_distance SHALL hold its value until the next capture.
REQ-022 algorithm_start SHALL be ignored outside IDLE.
- A start sampled in the same cycle as DONE SHALL be ignored.
REQ-023 Minimum latency: start sampled at edge k; mem_read_enable high at k+1; data valid at k+2 gives ready high at k+3.
REQ-024 There SHALL be no built-in timeout unless DUMMY_IF_TIMEOUT_EN is defined; WAIT then waits indefinitely.

Reset
REQ-025 While algorithm_reset is low, the FSM SHALL enter IDLE immediately, including mid-operation.
REQ-026 The following outputs SHALL be 0 during reset: mem_read_enable, mem_addr, shortest_distance, ready.
REQ-027 The latched base_address and datab registers SHALL be cleared to 0 during reset.
REQ-028 A read abandoned by reset SHALL leave the block unaffected: a late mem_read_ready is ignored in IDLE.

Configuration
REQ-029 Macro DUMMY_IF_TIMEOUT_EN defined: a counter SHALL run in REQ and WAIT.
- On reaching TIMEOUT_CYCLES without capture, mem_read_enable SHALL be deasserted and shortest_distance set to 32'hFFFFFFFF.
- The FSM SHALL then go to DONE and pulse ready.
REQ-030 Macro DUMMY_IF_TIMEOUT_EN undefined: no counter logic SHALL exist, and behaviour SHALL be per REQ-024.

Verification
REQ-031 Reset low then released, no start -> all outputs 0; ready never asserts.
REQ-032 Memory model returns mem[{addr[31:1],1'b0}] = that address, with a 3-cycle response and datab=0. Loop base_address=0..9 with one start each -> shortest_distance = 0,0,2,2,4,4,6,6,8,8, each with a single ready pulse.
REQ-033 base_address=0x10, datab=5, wait_request high 4 cycles -> mem_read_enable high 5 cycles with mem_addr=0x10 stable; result 0x15.
REQ-034 datab=0xFFFFFFFF, data=2 -> shortest_distance=1 (wrap); a second start pulsed while in WAIT -> exactly one read and one ready.
REQ-035 Reset asserted in WAIT, then mem_read_ready pulsed after release -> no ready, shortest_distance=0.
REQ-036 With DUMMY_IF_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no mem_read_ready -> ready pulses after 8 cycles with shortest_distance=0xFFFFFFFF.

Source files
------------

// File: rtl/dummy_interface.sv
// Single-read lookup engine: fetch one word over an Avalon-MM style read port and add an offset.
// Optional read-response timeout is enabled by defining DUMMY_IF_TIMEOUT_EN.
module dummy_interface #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        algorithm_clock,
  input  logic        algorithm_reset,
  input  logic        algorithm_start,
  input  logic        algorithm_enable,
  input  logic [31:0] base_address,
  input  logic [31:0] datab,
  output logic        mem_read_enable,
  output logic [31:0] mem_addr,
  input  logic        wait_request,
  input  logic        mem_read_ready,
  input  logic [31:0] mem_read_data,
  output logic [31:0] shortest_distance,
  output logic        ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] datab_q, datab_d;
  logic        rd_en_q, rd_en_d;
  logic [31:0] dist_q, dist_d;
  logic        ready_q, ready_d;

  // algorithm_enable is reserved and intentionally has no effect.
  logic unused_enable_s;
  assign unused_enable_s = algorithm_enable;

`ifdef DUMMY_IF_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_s;

  // Count cycles spent with a read outstanding; cleared whenever idle or done.
  always_comb begin
    tmo_cnt_d = 32'd0;
    if ((state_q == REQ) || (state_q == WAIT)) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end else begin
      tmo_cnt_d = 32'd0;
    end
  end

  assign timeout_s = (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Timeout counter register.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
    if (!algorithm_reset) begin
      tmo_cnt_q <= 32'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    datab_d = datab_q;
    rd_en_d = rd_en_q;
    dist_d  = dist_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (algorithm_start) begin
          base_d  = base_address;
          datab_d = datab;
          rd_en_d = 1'b1;
          state_d = REQ;
        end else begin
          rd_en_d = 1'b0;
        end
      end
      REQ: begin
`ifdef DUMMY_IF_TIMEOUT_EN
        if (timeout_s) begin
          rd_en_d = 1'b0;
          dist_d  = 32'hFFFF_FFFF;
          ready_d = 1'b1;
          state_d = DONE;
        end else
`endif
        if (!wait_request) begin
          rd_en_d = 1'b0;
          state_d = WAIT;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_read_ready) begin
          dist_d  = mem_read_data + datab_q;
          ready_d = 1'b1;
          state_d = DONE;
        end
`ifdef DUMMY_IF_TIMEOUT_EN
        else if (timeout_s) begin
          dist_d  = 32'hFFFF_FFFF;
          ready_d = 1'b1;
          state_d = DONE;
        end
`endif
        else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        rd_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
    if (!algorithm_reset) begin
      state_q <= IDLE;
      base_q  <= 32'd0;
      datab_q <= 32'd0;
      rd_en_q <= 1'b0;
      dist_q  <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      datab_q <= datab_d;
      rd_en_q <= rd_en_d;
      dist_q  <= dist_d;
      ready_q <= ready_d;
    end
  end

  assign mem_read_enable   = rd_en_q;
  assign mem_addr          = base_q;
  assign shortest_distance = dist_q;
  assign ready             = ready_q;

endmodule

// File: tb/tb_dummy_interface.sv
// Directed self-checking bench for dummy_interface with a small in-line memory responder.
module tb_dummy_interface;

`ifdef DUMMY_IF_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 256;
`endif

  logic        algorithm_clock = 1'b0;
  logic        algorithm_reset = 1'b1;
  logic        algorithm_start = 1'b0;
  logic        algorithm_enable = 1'b0;
  logic [31:0] base_address = 32'd0;
  logic [31:0] datab = 32'd0;
  logic        mem_read_enable;
  logic [31:0] mem_addr;
  logic        wait_request = 1'b0;
  logic        mem_read_ready = 1'b0;
  logic [31:0] mem_read_data = 32'd0;
  logic [31:0] shortest_distance;
  logic        ready;

  dummy_interface #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .algorithm_clock  (algorithm_clock),
    .algorithm_reset  (algorithm_reset),
    .algorithm_start  (algorithm_start),
    .algorithm_enable (algorithm_enable),
    .base_address     (base_address),
    .datab            (datab),
    .mem_read_enable  (mem_read_enable),
    .mem_addr         (mem_addr),
    .wait_request     (wait_request),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .shortest_distance(shortest_distance),
    .ready            (ready)
  );

  always #5 algorithm_clock = ~algorithm_clock;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int ready_cnt = 0;
  int rd_hi_cnt = 0;
  int accepts = 0;
  int cd = 0;
  int mem_lat = 3;
  bit mem_auto = 1'b0;
  logic [31:0] resp_data = 32'd0;
  logic [31:0] exp_tbl [10] = '{32'd0, 32'd0, 32'd2, 32'd2, 32'd4,
                                32'd4, 32'd6, 32'd6, 32'd8, 32'd8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: memory responder, then event counters, sampled 1ns after the edge.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    acc = mem_read_enable && !wait_request && algorithm_reset;
    a = mem_addr;
    @(posedge algorithm_clock);
    #1;
    mem_read_ready = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_read_ready = 1'b1;
        mem_read_data  = resp_data;
      end
    end
    if (acc) begin
      accepts++;
      if (mem_auto) begin
        resp_data = {a[31:1], 1'b0};
        if (mem_lat <= 1) begin
          mem_read_ready = 1'b1;
          mem_read_data  = resp_data;
        end else begin
          cd = mem_lat - 1;
        end
      end
    end
    if (ready === 1'b1) ready_cnt++;
    if (mem_read_enable === 1'b1) rd_hi_cnt++;
  endtask

  task automatic start_lookup(input logic [31:0] b, input logic [31:0] d);
    base_address    = b;
    datab           = d;
    algorithm_start = 1'b1;
    tick();
    algorithm_start = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    // Reset with no start: everything stays zero.
    algorithm_reset = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", {31'd0, mem_read_enable}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_dist", shortest_distance, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    algorithm_reset = 1'b1;
    ready_cnt = 0;
    rd_hi_cnt = 0;
    repeat (10) tick();
    check("idle_ready_cnt", 32'(ready_cnt), 32'd0);
    check("idle_rd_cnt", 32'(rd_hi_cnt), 32'd0);
    check("idle_dist", shortest_distance, 32'd0);

    // Address sweep against the even-address memory, 3-cycle response.
    mem_auto = 1'b1;
    mem_lat  = 3;
    algorithm_enable = 1'b1;
    for (int b = 0; b < 10; b++) begin
      ready_cnt = 0;
      accepts   = 0;
      start_lookup(32'(b), 32'd0);
      check("sweep_rd_en", {31'd0, mem_read_enable}, 32'd1);
      check("sweep_addr", mem_addr, 32'(b));
      wait_ready(20, "sweep_ready");
      check("sweep_dist", shortest_distance, exp_tbl[b]);
      repeat (3) tick();
      check("sweep_ready_cnt", 32'(ready_cnt), 32'd1);
      check("sweep_accepts", 32'(accepts), 32'd1);
    end
    algorithm_enable = 1'b0;

    // Minimum latency, and a start during DONE is ignored.
    mem_lat   = 1;
    ready_cnt = 0;
    start_lookup(32'd6, 32'h100);
    check("lat_rd_en", {31'd0, mem_read_enable}, 32'd1);
    tick();
    check("lat_rd_drop", {31'd0, mem_read_enable}, 32'd0);
    check("lat_no_ready", {31'd0, ready}, 32'd0);
    tick();
    check("lat_ready", {31'd0, ready}, 32'd1);
    check("lat_dist", shortest_distance, 32'h106);
    start_lookup(32'h20, 32'd0);
    check("done_start_ready", {31'd0, ready}, 32'd0);
    check("done_start_rd_en", {31'd0, mem_read_enable}, 32'd0);
    repeat (5) tick();
    check("done_start_ready_cnt", 32'(ready_cnt), 32'd1);
    check("done_start_addr", mem_addr, 32'd6);

    // Stalled request; a stray read-valid during REQ is ignored.
    mem_lat      = 3;
    accepts      = 0;
    rd_hi_cnt    = 0;
    wait_request = 1'b1;
    start_lookup(32'h10, 32'd5);
    for (int i = 0; i < 4; i++) begin
      check("stall_rd_en", {31'd0, mem_read_enable}, 32'd1);
      check("stall_addr", mem_addr, 32'h10);
      if (i == 1) begin
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h99;
      end
      tick();
    end
    wait_request = 1'b0;
    check("stall_rd_en_last", {31'd0, mem_read_enable}, 32'd1);
    tick();
    check("stall_rd_drop", {31'd0, mem_read_enable}, 32'd0);
    wait_ready(20, "stall_ready");
    check("stall_dist", shortest_distance, 32'h15);
    check("stall_rd_cycles", 32'(rd_hi_cnt), 32'd5);
    check("stall_accepts", 32'(accepts), 32'd1);

    // Wrap-around sum; second start while in WAIT is ignored.
    accepts   = 0;
    ready_cnt = 0;
    start_lookup(32'd2, 32'hFFFF_FFFF);
    tick();
    algorithm_start = 1'b1;
    tick();
    algorithm_start = 1'b0;
    wait_ready(20, "wrap_ready");
    check("wrap_dist", shortest_distance, 32'd1);
    repeat (6) tick();
    check("wrap_accepts", 32'(accepts), 32'd1);
    check("wrap_ready_cnt", 32'(ready_cnt), 32'd1);
    check("wrap_rd_en", {31'd0, mem_read_enable}, 32'd0);

    // Reset in WAIT, then a late read-valid after release.
    mem_auto = 1'b0;
    cd       = 0;
    start_lookup(32'd4, 32'd1);
    tick();
    algorithm_reset = 1'b0;
    #1;
    check("midrst_dist", shortest_distance, 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_rd_en", {31'd0, mem_read_enable}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    repeat (2) tick();
    algorithm_reset = 1'b1;
    ready_cnt = 0;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 32'h55;
    tick();
    repeat (4) tick();
    check("late_ready_cnt", 32'(ready_cnt), 32'd0);
    check("late_dist", shortest_distance, 32'd0);

`ifdef DUMMY_IF_TIMEOUT_EN
    // No response: timeout fires after TB_TMO cycles.
    begin
      int n;
      n = 0;
      start_lookup(32'd8, 32'd0);
      while (ready !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("tmo_ready", {31'd0, ready}, 32'd1);
      check("tmo_cycles", 32'(n), 32'd8);
      check("tmo_dist", shortest_distance, 32'hFFFF_FFFF);
      check("tmo_rd_en", {31'd0, mem_read_enable}, 32'd0);
    end
`else
    // No response: the block waits indefinitely, then completes on a late read-valid.
    ready_cnt = 0;
    start_lookup(32'd8, 32'd0);
    repeat (300) tick();
    check("nowait_ready_cnt", 32'(ready_cnt), 32'd0);
    check("nowait_rd_en", {31'd0, mem_read_enable}, 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 32'd7;
    tick();
    check("nowait_ready", {31'd0, ready}, 32'd1);
    check("nowait_dist", shortest_distance, 32'd7);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
